// File: rtl/lives_pkg.sv
// Shared defaults and width helper for the lives manager.
// Build option: define LIVES_BONUS_EN to enable extra-life handling on the bonus inputs.
package lives_pkg;

   localparam int DEF_MAX_LIVES     = 5;
   localparam int DEF_START_LIVES   = 3;
   localparam int DEF_INVULN_CYCLES = 4;

   // Wide enough for the largest legal window length (65535).
   localparam int TIMER_W = 16;

   function automatic int life_width(input int max_lives);
      return $clog2(max_lives + 1);
   endfunction

endpackage

// File: rtl/lives_channel.sv
// One player's lives: input registering, rise detection, saturating life counter,
// invulnerability timer and life_lost pulse. Bonus logic exists only with LIVES_BONUS_EN.
module lives_channel
   import lives_pkg::*;
#(
   parameter int MAX_LIVES     = DEF_MAX_LIVES,
   parameter int START_LIVES   = DEF_START_LIVES,
   parameter int INVULN_CYCLES = DEF_INVULN_CYCLES,
   parameter int LIFE_W        = life_width(DEF_MAX_LIVES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              hit,
   input  logic              bonus,
   output logic [LIFE_W-1:0] lives,
   output logic [LIFE_W-1:0] lives_next,
   output logic              invulnerable,
   output logic              life_lost
);

   logic               hit_q;
   logic               hit_prev;
   logic               hit_rise;
   logic               bonus_rise;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic               lost_next;
   logic               hit_ok;
   logic               bonus_ok;

   // History registers run every cycle so a level held across load/clear never re-triggers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q    <= 1'b0;
         hit_prev <= 1'b0;
      end else begin
         hit_q    <= hit;
         hit_prev <= hit_q;
      end
   end

   assign hit_rise = hit_q & ~hit_prev;

`ifdef LIVES_BONUS_EN
   logic bonus_q;
   logic bonus_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bonus_q    <= 1'b0;
         bonus_prev <= 1'b0;
      end else begin
         bonus_q    <= bonus;
         bonus_prev <= bonus_q;
      end
   end

   assign bonus_rise = bonus_q & ~bonus_prev;
`else
   logic bonus_unused;
   assign bonus_unused = bonus;
   assign bonus_rise   = 1'b0;
`endif

   assign hit_ok   = hit_rise && (lives != '0) && (timer == '0);
   assign bonus_ok = bonus_rise && (lives != '0);

   always_comb begin
      lives_next = lives;
      timer_next = (timer == '0) ? '0 : timer - TIMER_W'(1);
      lost_next  = 1'b0;
      if (load) begin
         lives_next = LIFE_W'(START_LIVES);
         timer_next = '0;
      end else if (clear) begin
         lives_next = '0;
         timer_next = '0;
      end else if (hit_ok) begin
         lost_next = 1'b1;
         // A simultaneous bonus cancels the decrement but the hit still opens a window.
         if (!bonus_ok) begin
            lives_next = lives - LIFE_W'(1);
         end
         timer_next = (lives_next != '0) ? TIMER_W'(INVULN_CYCLES) : '0;
      end else if (bonus_ok && (lives < LIFE_W'(MAX_LIVES))) begin
         lives_next = lives + LIFE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lives     <= LIFE_W'(START_LIVES);
         timer     <= '0;
         life_lost <= 1'b0;
      end else begin
         lives     <= lives_next;
         timer     <= timer_next;
         life_lost <= lost_next;
      end
   end

   assign invulnerable = (timer != '0);

endmodule

// File: rtl/lives_manager.sv
// Multi-player lives manager: resolves new_game/force_over priority and derives game_over.
// Build option: define LIVES_BONUS_EN to enable extra-life handling on the bonus inputs.
module lives_manager
   import lives_pkg::*;
#(
   parameter int  NUM_PLAYERS   = 2,
   parameter int  MAX_LIVES     = DEF_MAX_LIVES,
   parameter int  START_LIVES   = DEF_START_LIVES,
   parameter int  INVULN_CYCLES = DEF_INVULN_CYCLES,
   localparam int LIFE_W        = life_width(MAX_LIVES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          new_game,
   input  logic                          force_over,
   input  logic [NUM_PLAYERS-1:0]        hit,
   input  logic [NUM_PLAYERS-1:0]        bonus,
   output logic [NUM_PLAYERS*LIFE_W-1:0] lives_left,
   output logic [NUM_PLAYERS-1:0]        invulnerable,
   output logic [NUM_PLAYERS-1:0]        life_lost,
   output logic                          game_over
);

   logic                          load;
   logic                          clear;
   logic [NUM_PLAYERS*LIFE_W-1:0] lives_next;

   assign load  = new_game;
   assign clear = force_over & ~new_game;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
      lives_channel #(
         .MAX_LIVES    (MAX_LIVES),
         .START_LIVES  (START_LIVES),
         .INVULN_CYCLES(INVULN_CYCLES),
         .LIFE_W       (LIFE_W)
      ) u_channel (
         .clk         (clk),
         .rst         (rst),
         .load        (load),
         .clear       (clear),
         .hit         (hit[g]),
         .bonus       (bonus[g]),
         .lives       (lives_left[g*LIFE_W +: LIFE_W]),
         .lives_next  (lives_next[g*LIFE_W +: LIFE_W]),
         .invulnerable(invulnerable[g]),
         .life_lost   (life_lost[g])
      );
   end

   // Taken from next-state lives so game_over lines up with the all-zero lives_left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         game_over <= 1'b0;
      end else begin
         game_over <= (lives_next == '0);
      end
   end

endmodule
